hazard_ctrl: RTL and testbench

- Hazard and control-steering unit for the 4-stage pipeline (IF, ID, EX/MEM, WB).
- Reads the field outputs of the IF/ID, ID/EX/MEM and EX/MEM/WB pipeline registers.
- Drives back write-enable, bubble, flush and forwarding-select controls into those registers and the PC.
- Sequential core: a RUN/STALL/FLUSH state machine with down-counters, so that multi-cycle load-use stalls and redirect flushes are sequenced deterministically.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/hazard_ctrl_if.sv | 24 ++
 rtl/fwd_sel.sv | 24 ++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/control-steering unit.
// Holds the state and forwarding encodings, the default register-address
// width, and the control bundle driven back into the pipeline registers.
package pipe_pkg;
  localparam int RW = 6;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_WB = 2'd2
  } fwd_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exwb_flush;
  } ctl_t;

  localparam ctl_t CTL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CTL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctl_t CTL_EXFL  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctl_t CTL_WBFL  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline registers and the hazard unit.
//   master: pipeline side, drives the register fields, receives the controls
//   slave : hazard unit, reads the fields, drives the controls
interface hazard_ctrl_if #(parameter int RW = pipe_pkg::RW);
  logic [RW-1:0] id_rs, id_rt, ex_rd, wb_rd;
  logic          id_use_rs, id_use_rt;
  logic          ex_regwrite, ex_memread, ex_redirect;
  logic          wb_regwrite, wb_jumpm;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, exwb_flush;
  logic [1:0]    fwd_a, fwd_b, state_o;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_regwrite, ex_memread,
           ex_redirect, wb_rd, wb_regwrite, wb_jumpm,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, exwb_flush,
           fwd_a, fwd_b, state_o
  );
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_regwrite, ex_memread,
           ex_redirect, wb_rd, wb_regwrite, wb_jumpm,
    output pc_write, ifid_write, ifid_flush, idex_bubble, exwb_flush,
           fwd_a, fwd_b, state_o
  );
endinterface

// File: rtl/fwd_sel.sv
// Forwarding-source comparator for one ALU operand (pure combinational).
//   src                 : source register read by the ID instruction
//   ex_rd/ex_regwrite/ex_memread : producer in ID/EX/MEM
//   wb_rd/wb_regwrite   : producer in EX/MEM/WB
//   sel                 : FWD_EX, FWD_WB or FWD_RF
module fwd_sel #(
  parameter int RW = pipe_pkg::RW
) (
  input  logic [RW-1:0]   src,
  input  logic [RW-1:0]   ex_rd,
  input  logic [RW-1:0]   wb_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic            wb_regwrite,
  output pipe_pkg::fwd_t  sel
);
  // A load in EX has no result yet, so it never forwards from EX; the
  // younger producer (EX) wins over the older one (WB).
  always_comb begin
    if (ex_regwrite && !ex_memread && ex_rd == src) sel = pipe_pkg::FWD_EX;
    else if (wb_regwrite && wb_rd == src)          sel = pipe_pkg::FWD_WB;
    else                                           sel = pipe_pkg::FWD_RF;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and control-steering unit for the IF / ID / EX-MEM / WB pipeline.
//   clk, rst : clock and synchronous active-high reset
//   hz       : slave side of hazard_ctrl_if (register fields in, PC/pipeline
//              register controls, forwarding selects and debug state out)
// Controls are combinational from the current state and this cycle's fields;
// only state, down-counter and the "flush came from WB" flag are registered.
module hazard_ctrl #(
  parameter int RW         = pipe_pkg::RW,
  parameter int LOAD_STALL = 1,
  parameter int FLUSH_EX   = 1,
  parameter int FLUSH_WB   = 2
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave hz
);
  import pipe_pkg::*;

  localparam int NUM_OPS = 2;
  localparam logic [2:0] LS_CNT = 3'(LOAD_STALL - 1);
  localparam logic [2:0] EX_CNT = 3'(FLUSH_EX - 1);
  localparam logic [2:0] WB_CNT = 3'(FLUSH_WB - 1);

  state_t     state, nxt_state;
  logic [2:0] cnt, nxt_cnt;
  logic       wb_flag, nxt_flag;
  ctl_t       ctl;
  logic       load_use;

  logic [NUM_OPS-1:0][RW-1:0] src;
  fwd_t                       sel [NUM_OPS];

  assign src = {hz.id_rt, hz.id_rs};

  generate
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
      fwd_sel #(.RW(RW)) u_fwd (
        .src         (src[i]),
        .ex_rd       (hz.ex_rd),
        .wb_rd       (hz.wb_rd),
        .ex_regwrite (hz.ex_regwrite),
        .ex_memread  (hz.ex_memread),
        .wb_regwrite (hz.wb_regwrite),
        .sel         (sel[i])
      );
    end
  endgenerate

  assign load_use = hz.ex_memread & hz.ex_regwrite &
                    ((hz.id_use_rs & (hz.id_rs == hz.ex_rd)) |
                     (hz.id_use_rt & (hz.id_rt == hz.ex_rd)));

  // State-based behaviour first, then redirects override it: a redirect makes
  // whatever is stalled or being flushed wrong-path, so it restarts the
  // sequence from any state. Load-use is only looked at in RUN, since a
  // stall already covers it and a flush discards the ID instruction anyway.
  always_comb begin
    ctl       = CTL_RUN;
    nxt_state = ST_RUN;
    nxt_cnt   = '0;
    nxt_flag  = 1'b0;
    case (state)
      ST_STALL: begin
        ctl = CTL_STALL;
        if (cnt > 3'd1) begin
          nxt_state = ST_STALL;
          nxt_cnt   = cnt - 3'd1;
        end
      end
      ST_FLUSH: begin
        ctl            = CTL_EXFL;
        ctl.exwb_flush = wb_flag;
        if (cnt > 3'd1) begin
          nxt_state = ST_FLUSH;
          nxt_cnt   = cnt - 3'd1;
          nxt_flag  = wb_flag;
        end
      end
      ST_RUN: begin
        if (load_use) begin
          ctl = CTL_STALL;
          if (LOAD_STALL > 1) begin
            nxt_state = ST_STALL;
            nxt_cnt   = LS_CNT;
          end
        end
      end
      default: ;
    endcase

    if (hz.wb_jumpm) begin
      ctl       = CTL_WBFL;
      nxt_state = (FLUSH_WB > 1) ? ST_FLUSH : ST_RUN;
      nxt_cnt   = (FLUSH_WB > 1) ? WB_CNT : 3'd0;
      nxt_flag  = (FLUSH_WB > 1);
    end else if (hz.ex_redirect) begin
      ctl       = CTL_EXFL;
      nxt_state = (FLUSH_EX > 1) ? ST_FLUSH : ST_RUN;
      nxt_cnt   = (FLUSH_EX > 1) ? EX_CNT : 3'd0;
      nxt_flag  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      cnt     <= '0;
      wb_flag <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      wb_flag <= nxt_flag;
    end
  end

  // While in reset the pipeline is held frozen and emptied.
  assign hz.pc_write    = ~rst & ctl.pc_write;
  assign hz.ifid_write  = ~rst & ctl.ifid_write;
  assign hz.ifid_flush  =  rst | ctl.ifid_flush;
  assign hz.idex_bubble =  rst | ctl.idex_bubble;
  assign hz.exwb_flush  =  rst | ctl.exwb_flush;
  assign hz.fwd_a       = rst ? FWD_RF : sel[0];
  assign hz.fwd_b       = rst ? FWD_RF : sel[1];
  assign hz.state_o     = state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations driven by one stimulus
// stream, each checked every cycle against a counter-based reference model,
// plus directed scenarios with hand-computed expectations.
module tb_hazard_ctrl;
  localparam int ND = 3;
  localparam int LSV [ND] = '{1, 3, 2};
  localparam int FEV [ND] = '{1, 3, 2};
  localparam int FWV [ND] = '{2, 2, 1};

  typedef struct packed {
    logic [5:0] id_rs, id_rt;
    logic       id_use_rs, id_use_rt;
    logic [5:0] ex_rd;
    logic       ex_regwrite, ex_memread, ex_redirect;
    logic [5:0] wb_rd;
    logic       wb_regwrite, wb_jumpm;
  } stim_t;

  typedef struct packed {
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, exwb_flush;
    logic [1:0] fwd_a, fwd_b, state;
  } out_t;

  logic  clk = 1'b0;
  logic  rst;
  stim_t s;
  out_t  got [ND];
  int    n_chk = 0, n_fail = 0;
  bit    chk_on = 1'b0;

  // model: cycles of stall / flush still owed after the current one
  int stall_left [ND];
  int flush_left [ND];
  bit flush_wb   [ND];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < ND; g++) begin : gd
      hazard_ctrl_if ifc ();
      assign {ifc.id_rs, ifc.id_rt, ifc.id_use_rs, ifc.id_use_rt, ifc.ex_rd,
              ifc.ex_regwrite, ifc.ex_memread, ifc.ex_redirect, ifc.wb_rd,
              ifc.wb_regwrite, ifc.wb_jumpm} = s;
      hazard_ctrl #(.RW(6), .LOAD_STALL(LSV[g]), .FLUSH_EX(FEV[g]),
                    .FLUSH_WB(FWV[g])) dut (
        .clk (clk),
        .rst (rst),
        .hz  (ifc)
      );
      assign got[g] = {ifc.pc_write, ifc.ifid_write, ifc.ifid_flush,
                       ifc.idex_bubble, ifc.exwb_flush, ifc.fwd_a, ifc.fwd_b,
                       ifc.state_o};
    end
  endgenerate

  function automatic logic [1:0] fwd_of(logic [5:0] r);
    if (s.ex_regwrite && !s.ex_memread && s.ex_rd == r) return 2'd1;
    if (s.wb_regwrite && s.wb_rd == r) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit lu();
    return s.ex_memread && s.ex_regwrite &&
           ((s.id_use_rs && s.id_rs == s.ex_rd) || (s.id_use_rt && s.id_rt == s.ex_rd));
  endfunction

  function automatic out_t model_out(int d);
    out_t o;
    o.fwd_a = rst ? 2'd0 : fwd_of(s.id_rs);
    o.fwd_b = rst ? 2'd0 : fwd_of(s.id_rt);
    o.state = flush_left[d] > 0 ? 2'd2 : (stall_left[d] > 0 ? 2'd1 : 2'd0);
    if (rst)                   {o.pc_write, o.ifid_write, o.ifid_flush, o.idex_bubble, o.exwb_flush} = 5'b00111;
    else if (s.wb_jumpm)       {o.pc_write, o.ifid_write, o.ifid_flush, o.idex_bubble, o.exwb_flush} = 5'b11111;
    else if (s.ex_redirect)    {o.pc_write, o.ifid_write, o.ifid_flush, o.idex_bubble, o.exwb_flush} = 5'b11110;
    else if (flush_left[d] > 0) {o.pc_write, o.ifid_write, o.ifid_flush, o.idex_bubble, o.exwb_flush} = {4'b1111, flush_wb[d]};
    else if (stall_left[d] > 0 || lu())
                               {o.pc_write, o.ifid_write, o.ifid_flush, o.idex_bubble, o.exwb_flush} = 5'b00010;
    else                       {o.pc_write, o.ifid_write, o.ifid_flush, o.idex_bubble, o.exwb_flush} = 5'b11000;
    return o;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        stall_left[d] = 0; flush_left[d] = 0; flush_wb[d] = 1'b0;
      end else if (s.wb_jumpm) begin
        flush_left[d] = FWV[d] - 1; flush_wb[d] = 1'b1; stall_left[d] = 0;
      end else if (s.ex_redirect) begin
        flush_left[d] = FEV[d] - 1; flush_wb[d] = 1'b0; stall_left[d] = 0;
      end else if (flush_left[d] > 0) begin
        flush_left[d]--;
      end else if (stall_left[d] > 0) begin
        stall_left[d]--;
      end else if (lu()) begin
        stall_left[d] = LSV[d] - 1;
      end
    end
    chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < ND; d++) begin
        out_t e;
        e = model_out(d);
        n_chk++;
        if (got[d] !== e) begin
          n_fail++;
          $display("FAIL model dut%0d t=%0t: got %h expected %h", d, $time, got[d], e);
        end
      end
    end
  end

  task automatic chk(string nm, int got_v, int exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    s = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    s   = '0;
    // reset held two cycles
    @(negedge clk);
    chk("rst pc_write", got[0].pc_write, 0);
    chk("rst ifid_flush", got[0].ifid_flush, 1);
    chk("rst idex_bubble", got[0].idex_bubble, 1);
    chk("rst exwb_flush", got[0].exwb_flush, 1);
    tick();
    @(negedge clk);
    chk("rst2 pc_write", got[1].pc_write, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst state", got[0].state, 0);
    chk("post-rst pc_write", got[0].pc_write, 1);
    chk("post-rst fwd_a", got[0].fwd_a, 0);
    chk("post-rst fwd_b", got[0].fwd_b, 0);
    tick();

    // load-use on r5: A stalls once, B (LOAD_STALL=3) shows 0,1,1,0
    s.ex_rd = 6'd5; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
    s.id_rs = 6'd5; s.id_use_rs = 1'b1;
    @(negedge clk);
    chk("lu pc_write", got[0].pc_write, 0);
    chk("lu ifid_write", got[0].ifid_write, 0);
    chk("lu idex_bubble", got[0].idex_bubble, 1);
    chk("lu3 state c0", got[1].state, 0);
    tick();
    s.ex_memread = 1'b0; s.ex_regwrite = 1'b0; s.ex_rd = 6'd0;
    s.wb_rd = 6'd5; s.wb_regwrite = 1'b1;
    @(negedge clk);
    chk("lu after state", got[0].state, 0);
    chk("lu after pc_write", got[0].pc_write, 1);
    chk("lu after fwd_a", got[0].fwd_a, 2);
    chk("lu3 state c1", got[1].state, 1);
    chk("lu3 pc_write c1", got[1].pc_write, 0);
    tick();
    @(negedge clk);
    chk("lu3 state c2", got[1].state, 1);
    tick();
    @(negedge clk);
    chk("lu3 state c3", got[1].state, 0);
    chk("lu3 pc_write c3", got[1].pc_write, 1);
    idle(4);

    // EX redirect pulse, FLUSH_EX=1
    s.ex_redirect = 1'b1;
    @(negedge clk);
    chk("redir ifid_flush", got[0].ifid_flush, 1);
    chk("redir idex_bubble", got[0].idex_bubble, 1);
    chk("redir exwb_flush", got[0].exwb_flush, 0);
    tick();
    s.ex_redirect = 1'b0;
    @(negedge clk);
    chk("redir after state", got[0].state, 0);
    chk("redir after ifid_flush", got[0].ifid_flush, 0);
    idle(5);

    // JumpM in the second cycle of B's 3-cycle stall
    s.ex_rd = 6'd5; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
    s.id_rs = 6'd5; s.id_use_rs = 1'b1;
    tick();
    s = '0; s.wb_jumpm = 1'b1;
    @(negedge clk);
    chk("jm state in stall", got[1].state, 1);
    chk("jm pc_write", got[1].pc_write, 1);
    chk("jm exwb_flush", got[1].exwb_flush, 1);
    tick();
    s = '0;
    @(negedge clk);
    chk("jm flush state", got[1].state, 2);
    chk("jm flush ifid_flush", got[1].ifid_flush, 1);
    chk("jm flush idex_bubble", got[1].idex_bubble, 1);
    chk("jm flush exwb_flush", got[1].exwb_flush, 1);
    tick();
    @(negedge clk);
    chk("jm run state", got[1].state, 0);
    chk("jm run exwb_flush", got[1].exwb_flush, 0);
    idle(5);

    // forwarding priority on operand B
    s.ex_rd = 6'd9; s.wb_rd = 6'd9; s.ex_regwrite = 1'b1; s.wb_regwrite = 1'b1;
    s.id_rt = 6'd9; s.id_use_rt = 1'b1;
    @(negedge clk);
    chk("fwd_b ex", got[0].fwd_b, 1);
    tick();
    s.ex_regwrite = 1'b0;
    @(negedge clk);
    chk("fwd_b wb", got[0].fwd_b, 2);
    idle(2);

    // reset in the middle of B's stall
    s.ex_rd = 6'd7; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
    s.id_rt = 6'd7; s.id_use_rt = 1'b1;
    tick();
    s = '0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst state", got[1].state, 1);
    chk("mid-rst pc_write", got[1].pc_write, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("after mid-rst state", got[1].state, 0);
    chk("after mid-rst pc_write", got[1].pc_write, 1);
    idle(3);

    // randomized traffic with narrow register range to provoke matches
    for (int i = 0; i < 3000; i++) begin
      s.id_rs       = 6'($urandom_range(0, 3));
      s.id_rt       = 6'($urandom_range(0, 3));
      s.ex_rd       = 6'($urandom_range(0, 3));
      s.wb_rd       = 6'($urandom_range(0, 3));
      s.id_use_rs   = 1'($urandom_range(0, 1));
      s.id_use_rt   = 1'($urandom_range(0, 1));
      s.ex_regwrite = 1'($urandom_range(0, 1));
      s.wb_regwrite = 1'($urandom_range(0, 1));
      s.ex_memread  = ($urandom_range(0, 9) < 3);
      s.ex_redirect = ($urandom_range(0, 15) == 0);
      s.wb_jumpm    = ($urandom_range(0, 24) == 0);
      rst           = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
